// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   ADDR_W        : program counter / instruction memory address width
//   INSTR_W       : instruction word width
//   fetch_state_t : fetch FSM state encoding (START, REQ, HOLD)
package fetch_pkg;

    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        START = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Signal bundle between the fetch unit and its surroundings: the program
// counter register, instruction memory, the execute redirect path and the
// decode hand-off.
//   master : fetch unit side (drives pc_write/next_pc, imem_req/imem_addr,
//            ir_valid/ir/ir_pc)
//   slave  : environment side (drives pc, imem_ack/imem_rdata,
//            redirect/redirect_pc, ir_ready)
interface fetch_if;
    import fetch_pkg::*;

    logic [ADDR_W-1:0]  pc;
    logic               pc_write;
    logic [ADDR_W-1:0]  next_pc;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;

    logic               ir_valid;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  ir_pc;
    logic               ir_ready;

    modport master (
        input  pc, imem_ack, imem_rdata, redirect, redirect_pc, ir_ready,
        output pc_write, next_pc, imem_req, imem_addr, ir_valid, ir, ir_pc
    );

    modport slave (
        output pc, imem_ack, imem_rdata, redirect, redirect_pc, ir_ready,
        input  pc_write, next_pc, imem_req, imem_addr, ir_valid, ir, ir_pc
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory read at a time,
// loads the returned word into the instruction register for decode and
// steps or redirects the external program counter.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : fetch_if.master (pc, imem_*, redirect*, ir*)
//
// state | meaning
// START | idle after reset, no request; next cycle requests from pc
// REQ   | read outstanding on imem_addr, waiting for imem_ack
// HOLD  | ir holds a valid instruction, waiting for decode to take it
module fetch_unit
    import fetch_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    fetch_if.master bus
);

    fetch_state_t state;
    // Set when a redirect hits an outstanding read: that read's data belongs
    // to the abandoned path and must be thrown away when it returns.
    logic         discard;

    always_comb begin
        bus.pc_write = 1'b0;
        bus.next_pc  = '0;
        if (!reset) begin
            if (bus.redirect) begin
                bus.pc_write = 1'b1;
                bus.next_pc  = bus.redirect_pc;
            end else if (state == REQ && bus.imem_ack && !discard) begin
                bus.pc_write = 1'b1;
                bus.next_pc  = bus.pc + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= START;
            discard       <= 1'b0;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= '0;
            bus.ir_valid  <= 1'b0;
            bus.ir        <= '0;
            bus.ir_pc     <= '0;
        end else begin
            case (state)
                START: begin
                    // pc is being overwritten this cycle on a redirect, so
                    // the target is taken directly instead of the stale pc.
                    state         <= REQ;
                    bus.imem_req  <= 1'b1;
                    bus.imem_addr <= bus.redirect ? bus.redirect_pc : bus.pc;
                end

                REQ: begin
                    if (bus.redirect) begin
                        bus.ir_valid <= 1'b0;
                        if (bus.imem_ack) begin
                            // Read completes now: drop it and restart at target.
                            bus.imem_addr <= bus.redirect_pc;
                            discard       <= 1'b0;
                        end else begin
                            // Address must stay put while the read is in flight.
                            discard <= 1'b1;
                        end
                    end else if (bus.imem_ack) begin
                        if (discard) begin
                            // pc already carries the redirect target by now.
                            discard       <= 1'b0;
                            bus.imem_addr <= bus.pc;
                        end else begin
                            bus.ir       <= bus.imem_rdata;
                            bus.ir_pc    <= bus.imem_addr;
                            bus.ir_valid <= 1'b1;
                            bus.imem_req <= 1'b0;
                            state        <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (bus.redirect) begin
                        bus.ir_valid  <= 1'b0;
                        bus.imem_addr <= bus.redirect_pc;
                        bus.imem_req  <= 1'b1;
                        state         <= REQ;
                    end else if (bus.ir_ready) begin
                        bus.ir_valid  <= 1'b0;
                        bus.imem_addr <= bus.pc;
                        bus.imem_req  <= 1'b1;
                        state         <= REQ;
                    end
                end

                default: begin
                    state        <= START;
                    bus.imem_req <= 1'b0;
                    bus.ir_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized run, all checked against a transaction-level reference model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    fetch_if bus ();

    fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter register owned by the environment.
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_init;
    always @(posedge clk or posedge reset) begin
        if (reset)             pc_reg <= pc_init;
        else if (bus.pc_write) pc_reg <= bus.next_pc;
    end
    assign bus.pc = pc_reg;

    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        logic [31:0] h;
        h = (32'(a) * 32'h9E37) ^ 32'h5A5A;
        return h[INSTR_W-1:0];
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // want   : address the next instruction handed to decode must come from
    // stale  : the read currently outstanding belongs to an abandoned path
    logic              stale;
    logic [ADDR_W-1:0] want;
    logic              p_valid, p_req, p_ack, p_deliver, p_drop, p_redirect;
    logic              p_irv, p_ready;
    logic [ADDR_W-1:0] p_addr, p_irpc;
    logic [INSTR_W-1:0] p_ir;

    always @(negedge clk) begin
        logic deliver;
        logic exp_pw;
        int   exp_np;
        if (reset) begin
            p_valid = 1'b0;
            stale   = 1'b0;
            want    = pc_reg;
        end else begin
            if (p_valid) begin
                if (p_req && !p_ack) begin
                    check_eq("req_held", 32'(bus.imem_req), 32'd1);
                    check_eq("addr_held", 32'(bus.imem_addr), 32'(p_addr));
                end
                if (p_deliver) begin
                    check_eq("ir_valid_load", 32'(bus.ir_valid), 32'd1);
                    check_eq("ir_pc_order", 32'(bus.ir_pc), 32'(want));
                    check_eq("ir_data", 32'(bus.ir), 32'(mem_word(bus.ir_pc)));
                    want = ADDR_W'((int'(bus.ir_pc) + 1) % 1024);
                end
                if (p_drop)
                    check_eq("drop_no_load", 32'(bus.ir_valid), 32'd0);
                if (p_redirect)
                    check_eq("flush", 32'(bus.ir_valid), 32'd0);
                else if (p_irv && !p_ready) begin
                    check_eq("hold_valid", 32'(bus.ir_valid), 32'd1);
                    check_eq("hold_ir", 32'(bus.ir), 32'(p_ir));
                    check_eq("hold_ir_pc", 32'(bus.ir_pc), 32'(p_irpc));
                end else if (p_irv && p_ready)
                    check_eq("consumed", 32'(bus.ir_valid), 32'd0);
            end

            deliver = bus.imem_req && bus.imem_ack && !stale && !bus.redirect;
            exp_pw  = bus.redirect || deliver;
            exp_np  = bus.redirect ? int'(bus.redirect_pc) : (int'(bus.pc) + 1) % 1024;
            check_eq("pc_write", 32'(bus.pc_write), 32'(exp_pw));
            if (exp_pw) check_eq("next_pc", 32'(bus.next_pc), 32'(exp_np));
            if (bus.ir_valid) check_eq("no_req_in_hold", 32'(bus.imem_req), 32'd0);

            p_drop = bus.imem_req && bus.imem_ack && (stale || bus.redirect);
            if (bus.imem_req && bus.imem_ack) stale = 1'b0;
            else if (bus.imem_req && bus.redirect) stale = 1'b1;
            if (bus.redirect) want = bus.redirect_pc;

            p_valid    = 1'b1;
            p_req      = bus.imem_req;
            p_ack      = bus.imem_ack;
            p_addr     = bus.imem_addr;
            p_deliver  = deliver;
            p_redirect = bus.redirect;
            p_irv      = bus.ir_valid;
            p_ready    = bus.ir_ready;
            p_ir       = bus.ir;
            p_irpc     = bus.ir_pc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [ADDR_W-1:0] init);
        reset           = 1'b1;
        pc_init         = init;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [INSTR_W-1:0] h_ir;
        logic [ADDR_W-1:0]  h_pc;
        logic               seen;
        n_checks = 0;
        n_errors = 0;
        bus.imem_ack = 1'b0;
        bus.ir_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        pc_init = '0;
        reset = 1'b1;
        #2;
        check_eq("rst_req", 32'(bus.imem_req), 32'd0);
        check_eq("rst_pc_write", 32'(bus.pc_write), 32'd0);
        check_eq("rst_next_pc", 32'(bus.next_pc), 32'd0);
        check_eq("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        check_eq("rst_addr", 32'(bus.imem_addr), 32'd0);

        // First fetch after reset, zero-wait memory.
        bus.imem_ack = 1'b1;
        bus.ir_ready = 1'b1;
        do_reset(10'd0);
        check_eq("start_no_req", 32'(bus.imem_req), 32'd0);
        step();
        check_eq("first_req", 32'(bus.imem_req), 32'd1);
        check_eq("first_addr", 32'(bus.imem_addr), 32'd0);
        check_eq("first_pc_write", 32'(bus.pc_write), 32'd1);
        check_eq("first_next_pc", 32'(bus.next_pc), 32'd1);
        step();
        check_eq("first_ir_valid", 32'(bus.ir_valid), 32'd1);
        check_eq("first_ir", 32'(bus.ir), 32'(mem_word(10'd0)));
        check_eq("first_ir_pc", 32'(bus.ir_pc), 32'd0);

        // Throughput: one instruction per two cycles.
        cnt = 0;
        repeat (40) begin
            step();
            if (bus.ir_valid && bus.ir_ready) cnt++;
        end
        check_eq("throughput", 32'(cnt >= 19), 32'd1);

        // Decode stalls for 5 cycles while an instruction is held.
        check_eq("stall_start_hold", 32'(bus.ir_valid), 32'd1);
        bus.ir_ready = 1'b0;
        h_ir = bus.ir;
        h_pc = bus.ir_pc;
        repeat (5) begin
            step();
            check_eq("stall_ir", 32'(bus.ir), 32'(h_ir));
            check_eq("stall_ir_pc", 32'(bus.ir_pc), 32'(h_pc));
            check_eq("stall_req", 32'(bus.imem_req), 32'd0);
            check_eq("stall_pc_write", 32'(bus.pc_write), 32'd0);
        end
        bus.ir_ready = 1'b1;

        // PC wrap at the top of the address space.
        do_reset(10'd1023);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (bus.pc_write) begin
                seen = 1'b1;
                check_eq("wrap_next_pc", 32'(bus.next_pc), 32'd0);
            end
        end
        if (!seen) check_eq("wrap_timeout", 32'd0, 32'd1);

        // Redirect while a read is outstanding; ack arrives 3 cycles later.
        bus.imem_ack = 1'b0;
        do_reset(10'h010);
        step();
        check_eq("outst_addr", 32'(bus.imem_addr), 32'h010);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'h200;
        #1;
        check_eq("redir_pc_write", 32'(bus.pc_write), 32'd1);
        check_eq("redir_next_pc", 32'(bus.next_pc), 32'h200);
        step();
        bus.redirect = 1'b0;
        check_eq("outst_addr_kept", 32'(bus.imem_addr), 32'h010);
        step();
        step();
        bus.imem_ack = 1'b1;
        #1;
        check_eq("stale_no_pc_write", 32'(bus.pc_write), 32'd0);
        step();
        bus.imem_ack = 1'b0;
        check_eq("stale_ir_valid", 32'(bus.ir_valid), 32'd0);
        check_eq("refetch_req", 32'(bus.imem_req), 32'd1);
        check_eq("refetch_addr", 32'(bus.imem_addr), 32'h200);
        bus.imem_ack = 1'b1;
        step();
        bus.imem_ack = 1'b0;
        check_eq("target_ir_valid", 32'(bus.ir_valid), 32'd1);
        check_eq("target_ir_pc", 32'(bus.ir_pc), 32'h200);

        // Redirect coincident with the ack.
        step();
        check_eq("next_req_addr", 32'(bus.imem_addr), 32'h201);
        bus.imem_ack    = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'h3FF;
        #1;
        check_eq("coinc_next_pc", 32'(bus.next_pc), 32'h3FF);
        step();
        bus.redirect = 1'b0;
        bus.imem_ack = 1'b0;
        check_eq("coinc_ir_valid", 32'(bus.ir_valid), 32'd0);
        check_eq("coinc_addr", 32'(bus.imem_addr), 32'h3FF);
        check_eq("coinc_req", 32'(bus.imem_req), 32'd1);

        // Reset in the middle of an outstanding read, then a late ack.
        pc_init = 10'h055;
        reset   = 1'b1;
        #1;
        check_eq("midrst_req", 32'(bus.imem_req), 32'd0);
        check_eq("midrst_addr", 32'(bus.imem_addr), 32'd0);
        check_eq("midrst_ir_valid", 32'(bus.ir_valid), 32'd0);
        check_eq("midrst_ir", 32'(bus.ir), 32'd0);
        check_eq("midrst_ir_pc", 32'(bus.ir_pc), 32'd0);
        check_eq("midrst_pc_write", 32'(bus.pc_write), 32'd0);
        step();
        reset        = 1'b0;
        bus.imem_ack = 1'b1;
        step();
        bus.imem_ack = 1'b0;
        check_eq("late_ack_ir_valid", 32'(bus.ir_valid), 32'd0);
        check_eq("late_ack_addr", 32'(bus.imem_addr), 32'h055);

        // Randomized run.
        do_reset(ADDR_W'($urandom));
        repeat (3000) begin
            step();
            bus.imem_ack    = bus.imem_req && ($urandom_range(0, 99) < 45);
            bus.redirect    = !bus.redirect && ($urandom_range(0, 99) < 8);
            bus.redirect_pc = ADDR_W'($urandom);
            bus.ir_ready    = ($urandom_range(0, 99) < 60);
        end
        bus.redirect = 1'b0;
        bus.imem_ack = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
